keypad_emulator: RTL and testbench

//  Drives the row lines of a 4x4 matrix keypad in response to the column scan
//  of the keypad driver, so it answers the scan the way a physical key does.

---
 rtl/keypad_emulator.sv | 172 +++++++++++++++++
 tb/tb_keypad_emulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Keypad emulator: answers a 4x4 column scan on the row lines for one queued key press at a time.
// Optional contact bounce in PRESS/RELEASE is built only when BOUNCE_EN is defined.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 5000000,
    parameter int GAP_CYCLES    = 2500000,
    parameter int BOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] fila,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       key_done,
    output logic       busy,
    output logic [2:0] dbg_state
);

    // Handshake: a press is accepted on any clk edge where key_valid && key_ready;
    // key_ready is high only in IDLE, so key_valid is ignored while a press is running.

    localparam int MAX_HB = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_P  = (MAX_HB > BOUNCE_CYCLES) ? MAX_HB : BOUNCE_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    function automatic logic [CW-1:0] term_of(input int p);
        if (p <= 1) return '0;
        else return CW'(p - 1);
    endfunction

    localparam logic [CW-1:0] HOLD_TERM   = term_of(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_TERM    = term_of(GAP_CYCLES);
    localparam logic [CW-1:0] BOUNCE_TERM = term_of(BOUNCE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESS   = 3'd1,
        S_HOLD    = 3'd2,
        S_RELEASE = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      code_q, code_d;
    logic [3:0]      fila_q, fila_d;
    logic            done_q, done_d;
    logic            contact;
    logic            last;
    logic            bounce_bit;

`ifdef BOUNCE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign bounce_bit = lfsr_q[0];

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == S_PRESS || state_q == S_RELEASE)
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign bounce_bit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        done_d  = 1'b0;
        contact = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    code_d = key_code;
                    cnt_d  = '0;
`ifdef BOUNCE_EN
                    state_d = S_PRESS;
`else
                    state_d = S_HOLD;
`endif
                end
            end
            S_PRESS: begin
                last    = (cnt_q == BOUNCE_TERM);
                contact = last ? 1'b1 : bounce_bit;
                if (last) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                contact = 1'b1;
                if (cnt_q == HOLD_TERM) begin
                    cnt_d = '0;
`ifdef BOUNCE_EN
                    state_d = S_RELEASE;
`else
                    state_d = S_GAP;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                last    = (cnt_q == BOUNCE_TERM);
                contact = last ? 1'b0 : bounce_bit;
                if (last) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_TERM) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A closed contact connects row code[3:2] to column code[1:0]; overlapping low columns are not an error.
    always_comb begin
        fila_d = 4'b1111;
        if (contact && !col[code_q[1:0]])
            fila_d[code_q[3:2]] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= 4'b0000;
            fila_q  <= 4'b1111;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            fila_q  <= fila_d;
            done_q  <= done_d;
        end
    end

    assign fila      = fila_q;
    assign key_done  = done_q;
    assign key_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator (HOLD=20, GAP=10, BOUNCE=8); define BOUNCE_EN to cover bounce.
module tb_keypad_emulator;

    localparam int HOLD   = 20;
    localparam int GAP    = 10;
    localparam int BOUNCE = 8;
`ifdef BOUNCE_EN
    localparam int PB = BOUNCE;
`else
    localparam int PB = 0;
`endif
    localparam int TOTAL = PB + HOLD + PB + GAP;

    logic       clk;
    logic       reset;
    logic [3:0] col;
    logic [3:0] fila;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_done;
    logic       busy;
    logic [2:0] dbg_state;

    int n_cmp;
    int n_err;

    keypad_emulator #(
        .HOLD_CYCLES  (HOLD),
        .GAP_CYCLES   (GAP),
        .BOUNCE_CYCLES(BOUNCE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .col      (col),
        .fila     (fila),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_done (key_done),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (key_done) seen = 1'b1;
            else step();
        end
        check(tag, seen, 1'b1);
    endtask

    logic [3:0]  cols [4];
    logic [3:0]  prev_col;
    logic        prev_ct;
    logic        prev_known;
    logic [3:0]  exp_fila;
    logic [15:0] lf;
    int          done_cnt;
    int          toggles;
    logic        last_f0;

    initial begin
        n_cmp = 0;
        n_err = 0;
        cols[0] = 4'b1110; cols[1] = 4'b1101; cols[2] = 4'b1011; cols[3] = 4'b0111;
        reset = 1'b1;
        col = 4'b1111;
        key_code = 4'b0000;
        key_valid = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_fila", fila, 4'b1111);
        check("rst_ready", key_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", key_done, 1'b0);
        reset = 1'b0;
        step();
        check("post_rst_fila", fila, 4'b1111);
        check("post_rst_state", dbg_state, 3'd0);

        // Column scan response and press timing; key 0110 -> row 1, column 2
        key_code = 4'b0110;
        key_valid = 1'b1;
        col = cols[0];
        check("t3_ready_c0", key_ready, 1'b1);
        prev_col = col;
        prev_ct = 1'b0;
        prev_known = 1'b1;
        step();
        key_valid = 1'b0;
        key_code = 4'b1111;
        for (int cyc = 1; cyc <= TOTAL + 1; cyc++) begin
            exp_fila = (prev_ct && !prev_col[2]) ? 4'b1101 : 4'b1111;
            if (prev_known) check($sformatf("t2_fila_c%0d", cyc), fila, exp_fila);
            check($sformatf("t3_busy_c%0d", cyc), busy, (cyc <= TOTAL) ? 1'b1 : 1'b0);
            check($sformatf("t3_done_c%0d", cyc), key_done, (cyc == TOTAL + 1) ? 1'b1 : 1'b0);
            check($sformatf("t3_ready_c%0d", cyc), key_ready, (cyc == TOTAL + 1) ? 1'b1 : 1'b0);
            prev_known = !((cyc >= 1 && cyc <= PB) || (cyc > PB + HOLD && cyc <= 2 * PB + HOLD));
            prev_ct = (cyc > PB && cyc <= PB + HOLD);
            col = cols[cyc % 4];
            prev_col = col;
            step();
        end
        check("t3_idle_after", busy, 1'b0);

        // A held key_valid with a new code must not disturb the running press
        col = 4'b1001;
        key_code = 4'b0101;
        key_valid = 1'b1;
        step();
        key_code = 4'b1010;
        repeat (PB + 10) step();
        check("t4_first_code", fila, 4'b1101);
        check("t4_busy_mid", busy, 1'b1);
        wait_done("t4_first_done");
        check("t4_ready_at_done", key_ready, 1'b1);
        step();
        check("t4_second_start", busy, 1'b1);
        key_valid = 1'b0;
        repeat (PB + 10) step();
        check("t4_second_code", fila, 4'b1011);
        wait_done("t4_second_done");
        step();

        // Reset in the middle of HOLD
        col = 4'b1110;
        key_code = 4'b0000;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (PB + 10) step();
        check("t5_fila_closed", fila, 4'b1110);
        #2;
        reset = 1'b1;
        #1;
        check("t5_fila_async", fila, 4'b1111);
        check("t5_state", dbg_state, 3'd0);
        check("t5_busy", busy, 1'b0);
        check("t5_ready", key_ready, 1'b1);
        step();
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (key_done) done_cnt++;
            step();
        end
        check("t5_no_done", done_cnt, 0);
        check("t5_fila_idle", fila, 4'b1111);

`ifdef BOUNCE_EN
        // Bounce: LFSR freshly seeded by the reset above; key 0000, column 0 held low
        lf = 16'hACE1;
        col = 4'b1110;
        key_code = 4'b0000;
        key_valid = 1'b1;
        prev_ct = 1'b0;
        toggles = 0;
        last_f0 = 1'b1;
        step();
        key_valid = 1'b0;
        for (int cyc = 1; cyc <= TOTAL + 1; cyc++) begin
            check($sformatf("t6_fila_c%0d", cyc), fila, prev_ct ? 4'b1110 : 4'b1111);
            if (cyc >= 2 && cyc <= PB + 1 && fila[0] != last_f0) toggles++;
            last_f0 = fila[0];
            if (cyc >= 1 && cyc <= PB) begin
                prev_ct = (cyc == PB) ? 1'b1 : lf[0];
                lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            end else if (cyc > PB && cyc <= PB + HOLD) begin
                prev_ct = 1'b1;
            end else if (cyc > PB + HOLD && cyc <= 2 * PB + HOLD) begin
                prev_ct = (cyc == 2 * PB + HOLD) ? 1'b0 : lf[0];
                lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            end else begin
                prev_ct = 1'b0;
            end
            step();
        end
        check("t6_press_toggled", (toggles > 1) ? 1'b1 : 1'b0, 1'b1);
        check("t6_end_open", fila[0], 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
